node_window_feeder: RTL

- Producer side of the layer-node input interface: supplies the fifteen signed 8-bit activation inputs (A0x..A14x) that a layer node consumes.
- Accepts a serial stream of 16-bit node results (previous layer or ECG front end).
- Requantizes each sample to signed 8-bit with rounding and saturation.
- Shifts samples into a 15-tap window and presents the full window with a valid/ready handshake every STRIDE new samples.

---
 rtl/node_window_feeder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/node_window_feeder.sv
// Requantizes a 16-bit sample stream to signed 8-bit and presents a 15-tap
// sliding window to a layer node every STRIDE accepted samples.
module node_window_feeder #(
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned STRIDE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  A0x,
    output logic [7:0]  A1x,
    output logic [7:0]  A2x,
    output logic [7:0]  A3x,
    output logic [7:0]  A4x,
    output logic [7:0]  A5x,
    output logic [7:0]  A6x,
    output logic [7:0]  A7x,
    output logic [7:0]  A8x,
    output logic [7:0]  A9x,
    output logic [7:0]  A10x,
    output logic [7:0]  A11x,
    output logic [7:0]  A12x,
    output logic [7:0]  A13x,
    output logic [7:0]  A14x,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [15:0] win_cnt
);

    localparam int unsigned TAPS = 15;
    localparam int unsigned QW   = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned SW   = 17;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Half-LSB rounding bias; zero when no shift is applied.
    localparam logic [SW-1:0] RND = SW'((32'd1 << SHIFT) >> 1);

    logic [1:0]    state, state_nxt;
    logic [QW-1:0] taps     [TAPS];
    logic [QW-1:0] taps_nxt [TAPS];
    logic [CW-1:0] fill_cnt, fill_nxt;
    logic [CW-1:0] stride_cnt, stride_nxt;
    logic          wv_nxt;
    logic [15:0]   wcnt_nxt;

    logic signed [SW-1:0] sum, t;
    logic [QW-1:0]        q;
    logic                 accept, hs;

    assign in_ready = reset && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign hs       = win_valid && win_ready;

    // Round, shift and saturate the incoming sample.
    always_comb begin
        sum = $signed({in_data[15], in_data}) + $signed(RND);
        t   = sum >>> SHIFT;
        if (t > 17'sd127) begin
            q = 8'h7F;
        end else if (t < -17'sd128) begin
            q = 8'h80;
        end else begin
            q = t[QW-1:0];
        end
    end

    always_comb begin
        state_nxt  = state;
        taps_nxt   = taps;
        fill_nxt   = fill_cnt;
        stride_nxt = stride_cnt;
        wv_nxt     = win_valid;
        wcnt_nxt   = win_cnt;

        if (accept) begin
            for (int i = 0; i < 14; i++) begin
                taps_nxt[i] = taps[i+1];
            end
            taps_nxt[14] = q;
        end

        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (fill_cnt == CW'(TAPS - 1)) begin
                        fill_nxt   = '0;
                        stride_nxt = '0;
                        wv_nxt     = 1'b1;
                        state_nxt  = ST_RUN;
                    end else begin
                        fill_nxt = fill_cnt + CW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    wcnt_nxt = win_cnt + 16'd1;
                    // Unit stride with a same-cycle accept keeps windows back-to-back.
                    if (!(STRIDE == 1 && accept)) begin
                        wv_nxt     = 1'b0;
                        state_nxt  = ST_WAIT;
                        stride_nxt = accept ? CW'(1) : CW'(0);
                    end
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    if (stride_cnt + CW'(1) == CW'(STRIDE)) begin
                        stride_nxt = '0;
                        wv_nxt     = 1'b1;
                        state_nxt  = ST_RUN;
                    end else begin
                        stride_nxt = stride_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = ST_FILL;
        endcase

        if (flush) begin
            taps_nxt   = '{default: '0};
            fill_nxt   = '0;
            stride_nxt = '0;
            wv_nxt     = 1'b0;
            wcnt_nxt   = '0;
            state_nxt  = ST_FILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_FILL;
            taps       <= '{default: '0};
            fill_cnt   <= '0;
            stride_cnt <= '0;
            win_valid  <= 1'b0;
            win_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            taps       <= taps_nxt;
            fill_cnt   <= fill_nxt;
            stride_cnt <= stride_nxt;
            win_valid  <= wv_nxt;
            win_cnt    <= wcnt_nxt;
        end
    end

    assign A0x  = taps[0];
    assign A1x  = taps[1];
    assign A2x  = taps[2];
    assign A3x  = taps[3];
    assign A4x  = taps[4];
    assign A5x  = taps[5];
    assign A6x  = taps[6];
    assign A7x  = taps[7];
    assign A8x  = taps[8];
    assign A9x  = taps[9];
    assign A10x = taps[10];
    assign A11x = taps[11];
    assign A12x = taps[12];
    assign A13x = taps[13];
    assign A14x = taps[14];

endmodule
